// File: rtl/mem_sram_ctrl.sv
// rtl/mem_sram_ctrl.sv - MEM-stage 32-bit access sequencer onto a 16-bit async SRAM
// Optional feature macro: SRAM_ALIGN_CHECK_EN (misaligned/out-of-range access -> err, no SRAM cycle)
module mem_sram_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int SRAM_ADDR_W = 18,
    parameter int SRAM_DATA_W = 16,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   ready,
    output logic                   err,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int WORD_W = SRAM_ADDR_W - 1;
    localparam int CNT_W  = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   wr_op_q, wr_op_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [SRAM_DATA_W-1:0] rd_lo_q, rd_lo_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic                   err_q, err_d;

    logic              req;
    logic              bad_addr;
    logic [ADDR_W-1:0] addr_off;
    logic              hi_sel;
    logic              write_phase;
    logic              unused_addr;

    assign req      = rd_en | wr_en;
    assign addr_off = address - ADDR_W'(BASE_ADDR);
    assign unused_addr = ^{address[1:0], addr_off[1:0], addr_off[ADDR_W-1:SRAM_ADDR_W+1]};

`ifdef SRAM_ALIGN_CHECK_EN
    assign bad_addr = (address[1:0] != 2'b00) || (address < ADDR_W'(BASE_ADDR));
`else
    assign bad_addr = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_op_d   = wr_op_q;
        word_d    = word_q;
        wdata_d   = wdata_q;
        rd_lo_d   = rd_lo_q;
        rd_data_d = rd_data_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_op_d = wr_en;
                    word_d  = addr_off[SRAM_ADDR_W:2];
                    wdata_d = wr_data;
                    cnt_d   = CNT_LOAD;
                    state_d = bad_addr ? DONE : LOW;
                    err_d   = bad_addr;
                end
            end
            LOW: begin
                if (cnt_q == CNT_LAST) begin
                    if (!wr_op_q) rd_lo_d = sram_dq_in;
                    cnt_d   = CNT_LOAD;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_LAST;
                end
            end
            HIGH: begin
                if (cnt_q == CNT_LAST) begin
                    if (!wr_op_q) rd_data_d = {sram_dq_in, rd_lo_q};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_LAST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_op_q   <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            rd_lo_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_op_q   <= wr_op_d;
            word_q    <= word_d;
            wdata_q   <= wdata_d;
            rd_lo_q   <= rd_lo_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    // DONE releases the pipeline; the still-visible request is dropped on this edge
    assign ready = rst | (state_q == DONE) | ((state_q == IDLE) & ~req);

    assign hi_sel      = (state_q == HIGH);
    assign write_phase = wr_op_q & ((state_q == LOW) | (state_q == HIGH));
    assign sram_addr   = {word_q, hi_sel};
    assign sram_dq_oe  = write_phase;
    assign sram_dq_out = write_phase ? (hi_sel ? wdata_q[DATA_W-1:SRAM_DATA_W] : wdata_q[SRAM_DATA_W-1:0])
                                     : '0;
    // First HIGH cycle is a dead cycle so the address settles before the strobe
    assign sram_we_n   = ~(wr_op_q & ((state_q == LOW) | ((state_q == HIGH) & (cnt_q != CNT_LOAD))));

    assign rd_data = rd_data_q;
`ifdef SRAM_ALIGN_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb/tb_mem_sram_ctrl.sv - scoreboard bench for mem_sram_ctrl with a behavioural SRAM
module tb_mem_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, wr_data;
    logic [31:0] rd_data;
    logic        ready, err;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    mem_sram_ctrl dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .wr_data(wr_data), .rd_data(rd_data),
        .ready(ready), .err(err), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
    assign sram_dq_in = mem[sram_addr[7:0]];

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int completions = 0;
    logic prev_ready = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && ready && !prev_ready) begin
            exp_t e;
            completions++;
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("done_rd_data", rd_data, e.rd);
                chk("done_err", 32'(err), 32'(e.err));
            end
        end
        prev_ready <= ready;
    end

    logic [17:0] tr_addr [16];
    logic [15:0] tr_dq   [16];
    logic        tr_we   [16];
    logic        tr_oe   [16];
    int          tr_n;

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input logic exp_err, output int low_cnt);
        exp_t e;
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; address = a; wr_data = d;
        e.rd = exp_rd; e.err = exp_err;
        exp_q.push_back(e);
        low_cnt = 0;
        tr_n = 0;
        forever begin
            @(negedge clk);
            if (tr_n < 16) begin
                tr_addr[tr_n] = sram_addr; tr_dq[tr_n] = sram_dq_out;
                tr_we[tr_n] = sram_we_n;   tr_oe[tr_n] = sram_dq_oe;
                tr_n++;
            end
            if (ready) break;
            low_cnt++;
            if (low_cnt > 40) begin
                chk("req_timeout", 32'(low_cnt), 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic chk_no_sram_drive(input string name);
        logic any_oe = 1'b0;
        logic any_we = 1'b0;
        for (int i = 0; i < tr_n; i++) begin
            any_oe |= tr_oe[i];
            any_we |= ~tr_we[i];
        end
        chk({name, "_oe"}, 32'(any_oe), 32'd0);
        chk({name, "_we"}, 32'(any_we), 32'd0);
    endtask

    initial begin
        int lc;
        rst = 1'b1; rd_en = 1'b1; wr_en = 1'b1; address = 32'd1028; wr_data = 32'h0;
        @(negedge clk);
        chk("ready_in_reset", 32'(ready), 32'd1);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);

        // write 0xDEADBEEF to 1028: halves 2/3
        do_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0, 1'b0, lc);
        chk("wr_low_cycles", 32'(lc), 32'd5);
        chk("wr_we_trace", {26'd0, tr_we[0], tr_we[1], tr_we[2], tr_we[3], tr_we[4], tr_we[5]}, 32'b100101);
        chk("wr_low_addr0", 32'(tr_addr[1]), 32'd2);
        chk("wr_low_addr1", 32'(tr_addr[2]), 32'd2);
        chk("wr_low_dq", 32'(tr_dq[1]), 32'hBEEF);
        chk("wr_dead_addr", 32'(tr_addr[3]), 32'd3);
        chk("wr_high_addr", 32'(tr_addr[4]), 32'd3);
        chk("wr_high_dq", 32'(tr_dq[4]), 32'hDEAD);
        chk("wr_oe_low", 32'(tr_oe[1]), 32'd1);
        chk("mem2", 32'(mem[2]), 32'hBEEF);
        chk("mem3", 32'(mem[3]), 32'hDEAD);

        // read back
        do_req(1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF, 1'b0, lc);
        chk("rd_low_cycles", 32'(lc), 32'd5);
        chk_no_sram_drive("rd_bus");

        // simultaneous rd+wr: write wins, rd_data unchanged
        do_req(1'b1, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 1'b0, lc);
        chk("both_low_cycles", 32'(lc), 32'd5);
        chk("mem4", 32'(mem[4]), 32'h5678);
        chk("mem5", 32'(mem[5]), 32'h1234);
        repeat (3) @(negedge clk);
        chk("both_idle_ready", 32'(ready), 32'd1);

        // reset during first HIGH cycle of a write of 0xCAFEF00D to 1036
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1036; wr_data = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_dead_addr", 32'(sram_addr), 32'd7);
        chk("abort_dead_we", 32'(sram_we_n), 32'd1);
        rst = 1'b1; wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_rd_data", rd_data, 32'h0);
        chk("mem6", 32'(mem[6]), 32'hF00D);
        chk("mem7", 32'(mem[7]), 32'h1007);

        // misaligned read at 1030
`ifdef SRAM_ALIGN_CHECK_EN
        do_req(1'b1, 1'b0, 32'd1030, 32'h0, 32'h0, 1'b1, lc);
        chk("mis_low_cycles", 32'(lc), 32'd1);
`else
        do_req(1'b1, 1'b0, 32'd1030, 32'h0, 32'hDEADBEEF, 1'b0, lc);
        chk("mis_low_cycles", 32'(lc), 32'd5);
`endif
        chk_no_sram_drive("mis_bus");
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);

        // read word written by the simultaneous request
        do_req(1'b1, 1'b0, 32'd1032, 32'h0, 32'h12345678, 1'b0, lc);
        chk("rd2_low_cycles", 32'(lc), 32'd5);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("completions", 32'(completions), 32'd5);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
